// File: rtl/leaky_relu_bwd.sv
// Leaky-ReLU backward pass: dL/dx = dL/dy when x > 0, else 0.1 * dL/dy.
// Two-stage valid/ready pipeline with a frame counter that drives out_last.
// Optional macro LEAKY_RELU_BWD_SKID_EN adds a 2-entry input skid buffer
// and drives in_ready from a register.
module leaky_relu_bwd #(
  parameter int unsigned N_ELEM = 1024,
  parameter int unsigned CNT_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_x,
  input  logic [31:0] in_grad,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_grad,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  localparam int unsigned       FP_W       = 32;
  localparam int unsigned       MANT_W     = 24;
  localparam logic [MANT_W-1:0] SLOPE_MANT = 24'hCCCCCD;  // 1.6 * 2^-4 = 0.1
  localparam logic [9:0]        SLOPE_EADJ = 10'd4;       // 127 - 123
  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(N_ELEM - 1);

  logic            s1_valid;
  logic [FP_W-1:0] s1_grad;
  logic            s1_sel;
  logic [CNT_W-1:0] elem_cnt;

  logic            in_sel_c;
  logic            in_fire_c;
  logic            out_fire_c;
  logic            s2_ready_c;
  logic            s1_en_c;
  logic            src_valid_c;
  logic            src_sel_c;
  logic [FP_W-1:0] src_grad_c;
  logic [FP_W-1:0] mul_c;
  logic [FP_W-1:0] res_c;
  logic [CNT_W-1:0] cnt_nxt_c;

  // Slope select: strictly positive bit pattern (includes +Inf/+NaN)
  assign in_sel_c   = (in_x[30:0] != 31'd0) & ~in_x[31];
  assign in_fire_c  = in_valid & in_ready;
  assign out_fire_c = out_valid & out_ready;
  assign s2_ready_c = ~out_valid | out_ready;
  assign s1_en_c    = ~s1_valid | s2_ready_c;

`ifdef LEAKY_RELU_BWD_SKID_EN
  logic [1:0]  sk_cnt;
  logic [32:0] sk0;
  logic [32:0] sk1;
  logic        in_ready_q;
  logic        sk_pop_c;
  logic        sk_push_c;
  logic [32:0] in_word_c;

  assign in_word_c   = {in_sel_c, in_grad};
  assign sk_pop_c    = (sk_cnt != 2'd0) & s1_en_c;
  assign sk_push_c   = in_fire_c & ~((sk_cnt == 2'd0) & s1_en_c);
  assign src_valid_c = (sk_cnt != 2'd0) | in_fire_c;
  assign src_sel_c   = (sk_cnt != 2'd0) ? sk0[32]   : in_sel_c;
  assign src_grad_c  = (sk_cnt != 2'd0) ? sk0[31:0] : in_grad;
  assign in_ready    = in_ready_q & rst_n;

  // Skid FIFO; in_ready samples last cycle's empty flag, so entry 2 absorbs the lag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sk_cnt     <= 2'd0;
      sk0        <= 33'd0;
      sk1        <= 33'd0;
      in_ready_q <= 1'b0;
    end else begin
      in_ready_q <= (sk_cnt == 2'd0);
      sk_cnt     <= sk_cnt + 2'(sk_push_c) - 2'(sk_pop_c);
      if (sk_pop_c) begin
        if (sk_push_c && sk_cnt == 2'd1) sk0 <= in_word_c;
        else                             sk0 <= sk1;
        if (sk_push_c && sk_cnt == 2'd2) sk1 <= in_word_c;
      end else if (sk_push_c) begin
        if (sk_cnt == 2'd0) sk0 <= in_word_c;
        else                sk1 <= in_word_c;
      end
    end
  end
`else
  assign src_valid_c = in_fire_c;
  assign src_sel_c   = in_sel_c;
  assign src_grad_c  = in_grad;
  assign in_ready    = rst_n & s1_en_c;
`endif

  // Stage 1: capture gradient and slope select
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_grad  <= '0;
      s1_sel   <= 1'b0;
    end else if (s1_en_c) begin
      s1_valid <= src_valid_c;
      if (src_valid_c) begin
        s1_grad <= src_grad_c;
        s1_sel  <= src_sel_c;
      end
    end
  end

  // Multiply by 0.1, round-to-nearest-even; Inf/NaN pass unchanged, subnormals flush to zero
  always_comb begin
    logic [47:0]       prod;
    logic              norm;
    logic [22:0]       mant;
    logic              guard;
    logic              sticky;
    logic [MANT_W-1:0] mant_r;
    logic [9:0]        exp_r;
    prod   = 48'(({1'b1, s1_grad[22:0]})) * 48'(SLOPE_MANT);
    norm   = prod[47];
    mant   = norm ? prod[46:24] : prod[45:23];
    guard  = norm ? prod[23]    : prod[22];
    sticky = norm ? (|prod[22:0]) : (|prod[21:0]);
    mant_r = {1'b0, mant} + MANT_W'(guard & (sticky | mant[0]));
    exp_r  = 10'(s1_grad[30:23]) - SLOPE_EADJ + 10'(norm) + 10'(mant_r[23]);
    mul_c  = {s1_grad[31], exp_r[7:0], mant_r[22:0]};
    if (s1_grad[30:23] == 8'hFF) begin
      mul_c = s1_grad;
    end else if (s1_grad[30:23] == 8'h00 || exp_r[9] || exp_r == 10'd0) begin
      mul_c = {s1_grad[31], 31'd0};
    end
  end

  assign res_c     = s1_sel ? s1_grad : mul_c;
  assign cnt_nxt_c = out_fire_c ? (out_last ? '0 : elem_cnt + CNT_W'(1)) : elem_cnt;

  // Stage 2 and frame counter; out_last tags the element that will sit at index N_ELEM-1
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_grad  <= '0;
      out_last  <= 1'b0;
      elem_cnt  <= '0;
    end else begin
      elem_cnt <= cnt_nxt_c;
      if (s2_ready_c) begin
        out_valid <= s1_valid;
        out_last  <= s1_valid & (cnt_nxt_c == LAST_IDX);
        if (s1_valid) out_grad <= res_c;
      end
    end
  end

endmodule

// File: tb/tb_leaky_relu_bwd.sv
// Directed bench for leaky_relu_bwd with N_ELEM=4: vector table, latency,
// throughput, backpressure, framing and reset-in-flight sequences.
module tb_leaky_relu_bwd;

  localparam int unsigned NE = 4;

  typedef struct {
    logic [31:0] x;
    logic [31:0] g;
    logic [31:0] e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_x;
  logic [31:0] in_grad;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_grad;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int          mode = 0;      // 0: out_ready low, 1: high, 2: pseudo-random
  logic        rnd_bit = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          ord = 0;

  logic [31:0] got_g[$];
  logic        got_l[$];
  logic [31:0] exp_g[$];

  logic        hold_prev = 1'b0;
  logic [31:0] prev_g = 32'd0;
  logic        prev_l = 1'b0;

  vec_t        vecs[16];
  logic [31:0] pool_g[8];
  logic [31:0] pool_p[8];

  leaky_relu_bwd #(.N_ELEM(NE), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_x      (in_x),
    .in_grad   (in_grad),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_grad  (out_grad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  assign out_ready = (mode == 1) || (mode == 2 && rnd_bit);

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    rnd_bit = 1'($urandom_range(0, 1));
  end

  // Output monitor: records transfers and checks stability while stalled
  always @(negedge clk) begin
    if (rst_n && hold_prev) begin
      n_cmp++;
      if (!out_valid || out_grad !== prev_g || out_last !== prev_l) begin
        n_bad++;
        $display("FAIL stall_hold: got v=%b g=%h l=%b, want v=1 g=%h l=%b",
                 out_valid, out_grad, out_last, prev_g, prev_l);
      end
    end
    hold_prev = rst_n && out_valid && !out_ready;
    prev_g    = out_grad;
    prev_l    = out_last;
    if (rst_n && out_valid && out_ready) begin
      got_g.push_back(out_grad);
      got_l.push_back(out_last);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Present one pair and hold until accepted; called and returns at posedge+1
  task automatic send(input logic [31:0] x, input logic [31:0] g, input logic [31:0] e);
    int   b;
    logic rdy;
    b = 0;
    rdy = 1'b0;
    in_x = x;
    in_grad = g;
    in_valid = 1'b1;
    while (!rdy && b < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      b++;
    end
    in_valid = 1'b0;
    if (rdy) exp_g.push_back(e);
    else begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1 within 200 cycles");
    end
  endtask

  // Wait for all expected outputs, compare in order including out_last framing
  task automatic drain();
    int b;
    int n;
    b = 0;
    while (got_g.size() < exp_g.size() && b < 500) begin
      @(negedge clk);
      b++;
    end
    @(negedge clk);
    chk("out_count", 32'(got_g.size()), 32'(exp_g.size()));
    n = (got_g.size() < exp_g.size()) ? got_g.size() : exp_g.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("grad[%0d]", ord), got_g[i], exp_g[i]);
      chk($sformatf("last[%0d]", ord), 32'(got_l[i]), 32'((ord % NE) == NE - 1));
      ord++;
    end
    got_g.delete();
    got_l.delete();
    exp_g.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    got_g.delete();
    got_l.delete();
    exp_g.delete();
    ord = 0;
    rst_n = 1'b1;
  endtask

  initial begin
    int t0;
    int k;
    logic [31:0] x;
    logic [31:0] e;

    vecs[0]  = '{32'h40000000, 32'h3F800000, 32'h3F800000};
    vecs[1]  = '{32'hC0000000, 32'h3F800000, 32'h3DCCCCCD};
    vecs[2]  = '{32'h00000000, 32'h40200000, 32'h3E800000};
    vecs[3]  = '{32'h80000000, 32'h40000000, 32'h3E4CCCCD};
    vecs[4]  = '{32'h00000001, 32'h40400000, 32'h40400000};
    vecs[5]  = '{32'h3F800000, 32'hBF800000, 32'hBF800000};
    vecs[6]  = '{32'hBF800000, 32'hBF800000, 32'hBDCCCCCD};
    vecs[7]  = '{32'h7F800000, 32'h40400000, 32'h40400000};
    vecs[8]  = '{32'hFF800000, 32'h40400000, 32'h3E99999A};
    vecs[9]  = '{32'h7FC00000, 32'h41200000, 32'h41200000};
    vecs[10] = '{32'hFFC00000, 32'h41200000, 32'h3F800000};
    vecs[11] = '{32'hC2000000, 32'h7F800000, 32'h7F800000};
    vecs[12] = '{32'hC2000000, 32'h7FC00001, 32'h7FC00001};
    vecs[13] = '{32'hC2000000, 32'h80000000, 32'h80000000};
    vecs[14] = '{32'hC2000000, 32'h00000000, 32'h00000000};
    vecs[15] = '{32'h80000000, 32'hC0400000, 32'hBE99999A};

    pool_g = '{32'h3F800000, 32'h40200000, 32'hBF800000, 32'h41200000,
               32'h40000000, 32'h40400000, 32'h7F800000, 32'h00000000};
    pool_p = '{32'h3DCCCCCD, 32'h3E800000, 32'hBDCCCCCD, 32'h3F800000,
               32'h3E4CCCCD, 32'h3E99999A, 32'h7F800000, 32'h00000000};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_x = 32'd0;
    in_grad = 32'd0;
    mode = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_grad", out_grad, 32'd0);
    chk("rst_cnt", 32'(dut.elem_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    mode = 1;

    // Latency: out_valid exactly two cycles after the transfer
    send(vecs[0].x, vecs[0].g, vecs[0].e);
    @(negedge clk);
    chk("lat_cycle1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    chk("lat_cycle2_grad", out_grad, 32'h3F800000);
    @(posedge clk);
    #1;
    drain();

    // Vector table streamed back to back: one accept per cycle
    t0 = cyc;
    for (int i = 0; i < 16; i++) send(vecs[i].x, vecs[i].g, vecs[i].e);
    chk("throughput_cycles", 32'(cyc - t0), 32'd16);
    drain();

    // Backpressure with random out_ready and random input gaps
    mode = 2;
    for (int i = 0; i < 8; i++) begin
      k = $urandom_range(0, 7);
      x = $urandom;
      if (i == 2) x = 32'h00000000;
      if (i == 5) x = 32'h80000000;
      e = (x[30:0] != 31'd0 && !x[31]) ? pool_g[k] : pool_p[k];
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(x, pool_g[k], e);
    end
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    mode = 1;
    drain();

    // Framing: 9 elements after reset, last on 4 and 8, counter ends at 1
    do_reset();
    for (int i = 0; i < 9; i++) send(vecs[i].x, vecs[i].g, vecs[i].e);
    drain();
    chk("cnt_after_9", 32'(dut.elem_cnt), 32'd1);

    // Reset with two elements in flight
    mode = 0;
    send(vecs[1].x, vecs[1].g, vecs[1].e);
    send(vecs[2].x, vecs[2].g, vecs[2].e);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd0);
    got_g.delete();
    got_l.delete();
    exp_g.delete();
    ord = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode = 1;
    repeat (4) @(negedge clk);
    chk("no_stale_outputs", 32'(got_g.size()), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 3; i < 7; i++) send(vecs[i].x, vecs[i].g, vecs[i].e);
    drain();

`ifdef LEAKY_RELU_BWD_SKID_EN
    // Registered in_ready: four accepts under full stall, no same-cycle out_ready path
    begin
      int   acc;
      logic r;
      acc = 0;
      mode = 0;
      for (int i = 0; i < 8; i++) begin
        in_x = vecs[acc].x;
        in_grad = vecs[acc].g;
        in_valid = 1'b1;
        @(negedge clk);
        r = in_ready;
        @(posedge clk);
        #1;
        if (r) begin
          exp_g.push_back(vecs[acc].e);
          acc++;
        end
      end
      in_valid = 1'b0;
      chk("skid_accepts", 32'(acc), 32'd4);
      r = in_ready;
      mode = 1;
      #1;
      chk("skid_ready_toggle_hi", 32'(in_ready), 32'(r));
      mode = 0;
      #1;
      chk("skid_ready_toggle_lo", 32'(in_ready), 32'(r));
      @(posedge clk);
      #1;
      mode = 1;
      drain();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish before 500000");
    $fatal(1);
  end

endmodule

// File: doc/leaky_relu_bwd.md
LEAKY_RELU_BWD -- requirements
Module: leaky_relu_bwd

Interface
REQ-001 Parameter: N_ELEM, default 1024, elements per frame; out_last marks the final gradient of each frame.
REQ-002 Parameter: CNT_W, default 16, element counter width; N_ELEM SHALL be at most 2^CNT_W.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst_n  input  1  synchronous, active-low reset.
REQ-005 Port: in_x  input  32  forward-pass activation input, IEEE-754 single.
REQ-006 Port: in_grad  input  32  upstream gradient dL/dy, IEEE-754 single.
REQ-007 Port: in_valid  input  1  in_x/in_grad valid.
REQ-008 Port: in_ready  output  1  block accepts the input pair this cycle.
REQ-009 Port: out_grad  output  32  dL/dx, IEEE-754 single.
REQ-010 Port: out_valid  output  1  out_grad valid.
REQ-011 Port: out_ready  input  1  downstream accepts out_grad.
REQ-012 Port: out_last  output  1  qualifies out_grad as the last element of a frame.

Function
REQ-013 The input transfer SHALL occur when in_valid and in_ready are both 1; the output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-014 Slope select SHALL be: sel = 1 when in_x is nonzero and in_x[31] = 0, else 0; +0, -0 and all negative values give sel = 0.
REQ-015 out_grad SHALL be in_grad when sel = 1, else the FP_Mul product of in_grad and 32'h3DCCCCCD (0.1).
REQ-016 The datapath SHALL be 2 stages: stage 1 registers in_grad and sel; stage 2 registers the selected result and is out_valid.
REQ-017 Latency SHALL be exactly 2 clk cycles from the input transfer to out_valid when out_ready is held at 1.
REQ-018 Throughput SHALL be one element per cycle when out_ready is held at 1.
REQ-019 Each stage SHALL load when it is empty or its contents advance in the same cycle; otherwise it SHALL hold its value.
REQ-020 out_grad, out_valid and out_last SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-021 No element SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-022 Element counter SHALL increment on each output transfer.
REQ-023 out_last SHALL be 1 when the counter equals N_ELEM-1 and out_valid = 1.
REQ-024 The counter SHALL wrap to 0 on the output transfer where out_last = 1.
REQ-025 NaN/Inf in in_x SHALL follow REQ-014 bit rules: positive NaN/Inf gives sel = 1 and negative gives sel = 0.
REQ-026 NaN/Inf in in_grad SHALL pass through FP_Mul unmodified by this block.

Reset
REQ-027 When rst_n = 0 at a clk edge, both stage valids, out_valid, out_last and the element counter SHALL clear to 0.
REQ-028 out_grad SHALL reset to 32'h00000000.
REQ-029 in_ready SHALL be 0 while rst_n = 0.
REQ-030 Reset mid-frame SHALL discard in-flight elements, and the next frame SHALL start at count 0.

Configuration
REQ-031 Macro LEAKY_RELU_BWD_SKID_EN, when defined, SHALL add a 2-entry skid buffer at the input and drive in_ready from a register: 1 iff the skid buffer is empty.
REQ-032 With LEAKY_RELU_BWD_SKID_EN defined, in_ready SHALL have no combinational path from out_ready, and latency SHALL stay 2 cycles when the skid buffer is empty.
REQ-033 With LEAKY_RELU_BWD_SKID_EN undefined, in_ready SHALL be combinational: 1 when stage 1 is empty or stage 1 advances this cycle.

Verification
REQ-034 Positive-slope scenario: in_x=32'h40000000, in_grad=32'h3F800000, out_ready=1 -> out_grad=32'h3F800000 exactly 2 cycles later.
REQ-035 Negative-slope scenario: in_x=32'hC0000000, in_grad=32'h3F800000 -> out_grad=32'h3DCCCCCD; in_x=32'h00000000, in_grad=32'h40200000 -> out_grad=32'h3E800000.
REQ-036 Backpressure scenario: stream 8 random pairs with out_ready toggling pseudo-randomly -> 8 outputs, in order, matching the model, stable while stalled.
REQ-037 Framing scenario: N_ELEM=4, stream 9 elements -> out_last=1 on outputs 4 and 8 only, and the counter reads 1 after output 9.
REQ-038 Reset scenario: rst_n=0 with 2 elements in flight -> out_valid=0 the next cycle, no stale outputs appear, and out_last lands on the N_ELEM-th post-reset element.
REQ-039 Ready-path scenario: with LEAKY_RELU_BWD_SKID_EN defined, hold out_ready=0 -> in_ready falls only after 4 accepts, and a toggle on out_ready alone never changes in_ready in the same cycle.
